// File: rtl/shot_judge_if.sv
// Frame-rate bus between the ball tracker and the shot judge.
interface shot_judge_if;
  logic       shotStart;
  logic [9:0] releaseX;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic [1:0] madeShot;
  logic       shotFinished;
  logic       busy;

  modport master (
    output shotStart, releaseX, ballX, ballY,
    input  madeShot, shotFinished, busy
  );

  modport slave (
    input  shotStart, releaseX, ballX, ballY,
    output madeShot, shotFinished, busy
  );
endinterface

// File: rtl/shot_judge.sv
// Judges a basketball shot from per-frame ball positions: make (2/3), miss, or still flying.
// Define SHOT_TIMEOUT_EN to add a flight timer that forces a miss after TIMEOUT_FRAMES frames.
module shot_judge #(
  parameter int HOOP_X_MIN     = 560,
  parameter int HOOP_X_MAX     = 600,
  parameter int RIM_Y          = 160,
  parameter int FLOOR_Y        = 440,
  parameter int THREE_X        = 320,
  parameter int HOLD_FRAMES    = 4,
  parameter int TIMEOUT_FRAMES = 255
) (
  input  logic         frame_clk,
  input  logic         reset,
  shot_judge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FLIGHT, ARMED, RESULT} state_t;

  localparam logic [9:0] X_MIN    = 10'(HOOP_X_MIN);
  localparam logic [9:0] X_MAX    = 10'(HOOP_X_MAX);
  localparam logic [9:0] RIM      = 10'(RIM_Y);
  localparam logic [9:0] FLOOR    = 10'(FLOOR_Y);
  localparam logic [9:0] THREE    = 10'(THREE_X);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_FRAMES);

  state_t     state;
  logic [1:0] made_shot;
  logic       shot_finished;
  logic       busy_q;
  logic       is_three;
  logic [9:0] prev_y;
  logic [7:0] hold_cnt;

  logic in_window;
  logic crossing;
  logic at_floor;
  logic time_up;

  assign in_window = (bus.ballX >= X_MIN) && (bus.ballX <= X_MAX);
  assign crossing  = (prev_y < RIM) && (bus.ballY >= RIM);
  assign at_floor  = (bus.ballY >= FLOOR);

`ifdef SHOT_TIMEOUT_EN
  localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT_FRAMES);
  logic [7:0] timer;

  // Counts frames spent in flight; held at zero while idle so each shot starts fresh.
  always_ff @(posedge frame_clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else if ((state == FLIGHT || state == ARMED) && timer != 8'hFF) begin
      timer <= timer + 8'd1;
    end
  end

  assign time_up = ({1'b0, timer} + 9'd1) >= TIMEOUT_LIM;
`else
  assign time_up = 1'b0;
`endif

  always_ff @(posedge frame_clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      made_shot     <= 2'b00;
      shot_finished <= 1'b0;
      busy_q        <= 1'b0;
      is_three      <= 1'b0;
      prev_y        <= '0;
      hold_cnt      <= '0;
    end else begin
      prev_y <= bus.ballY;
      case (state)
        IDLE: begin
          if (bus.shotStart) begin
            is_three  <= (bus.releaseX < THREE);
            made_shot <= 2'b00;
            busy_q    <= 1'b1;
            state     <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (at_floor || time_up) begin
            made_shot     <= 2'b01;
            shot_finished <= 1'b1;
            hold_cnt      <= 8'd1;
            state         <= RESULT;
          end else if (bus.ballY < RIM) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          // A make beats a floor/timeout miss seen in the same frame.
          if (crossing && in_window) begin
            made_shot     <= is_three ? 2'b11 : 2'b10;
            shot_finished <= 1'b1;
            hold_cnt      <= 8'd1;
            state         <= RESULT;
          end else if (at_floor || time_up) begin
            made_shot     <= 2'b01;
            shot_finished <= 1'b1;
            hold_cnt      <= 8'd1;
            state         <= RESULT;
          end else if (crossing) begin
            state <= FLIGHT;
          end
        end
        RESULT: begin
          if (hold_cnt >= HOLD_LIM) begin
            shot_finished <= 1'b0;
            busy_q        <= 1'b0;
            state         <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.madeShot     = made_shot;
  assign bus.shotFinished = shot_finished;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_shot_judge.sv
// Randomized self-checking bench for shot_judge, using a trajectory-level outcome model.
module tb_shot_judge;
  localparam int START_Y = 300;

  logic frame_clk = 1'b0;
  logic reset;
  shot_judge_if bus();

  shot_judge dut (
    .frame_clk (frame_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;
  int tx[$];
  int ty[$];

  task automatic push(input int x, input int y);
    tx.push_back(x);
    ty.push_back(y);
  endtask

  task automatic clear_traj();
    tx.delete();
    ty.delete();
  endtask

  task automatic cross_traj(input int xc, input int yc);
    clear_traj();
    push(580, 250);
    push(580, 150);
    push(xc, yc);
    push(500, 300);
    push(500, 440);
  endtask

  // Outcome of a whole shot: the first downward rim pass inside the hoop after the
  // ball was seen above the rim scores; otherwise the first floor touch is a miss.
  task automatic run_shot(input logic [9:0] rel, input string name);
    int res_k;
    logic [1:0] res_v;
    bit above;
    int py;
    int n;
    logic [1:0] exp_m;
    logic exp_f;
    logic exp_b;
    res_k = -1;
    res_v = 2'b00;
    above = 1'b0;
    py = START_Y;
    for (int k = 0; k < ty.size(); k++) begin
      if (above && py < 160 && ty[k] >= 160) begin
        if (tx[k] >= 560 && tx[k] <= 600) begin
          res_v = (rel < 10'd320) ? 2'b11 : 2'b10;
          res_k = k;
          break;
        end
        above = 1'b0;
      end
      if (ty[k] >= 440) begin
        res_v = 2'b01;
        res_k = k;
        break;
      end
      if (ty[k] < 160) above = 1'b1;
      py = ty[k];
    end

    @(negedge frame_clk);
    bus.shotStart = 1'b1;
    bus.releaseX  = rel;
    bus.ballX     = 10'd0;
    bus.ballY     = 10'(START_Y);
    @(negedge frame_clk);
    bus.shotStart = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.madeShot !== 2'b00 || bus.shotFinished !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s start: busy=%b made=%b fin=%b required busy=1 made=00 fin=0",
               name, bus.busy, bus.madeShot, bus.shotFinished);
    end

    n = (res_k < 0) ? ty.size() : res_k + 1;
    for (int k = 0; k < n; k++) begin
      bus.ballX     = 10'(tx[k]);
      bus.ballY     = 10'(ty[k]);
      bus.shotStart = ($urandom_range(0, 3) == 0);
      bus.releaseX  = 10'($urandom_range(0, 1023));
      @(negedge frame_clk);
      exp_m = (k == res_k) ? res_v : 2'b00;
      exp_f = (k == res_k);
      total++;
      if (bus.busy !== 1'b1 || bus.madeShot !== exp_m || bus.shotFinished !== exp_f) begin
        bad++;
        $display("[TB] FAIL %s frame %0d: busy=%b made=%b fin=%b required busy=1 made=%b fin=%b",
                 name, k, bus.busy, bus.madeShot, bus.shotFinished, exp_m, exp_f);
      end
    end
    bus.shotStart = 1'b0;

    if (res_k >= 0) begin
      for (int h = 1; h <= 4; h++) begin
        bus.shotStart = 1'($urandom_range(0, 1));
        bus.releaseX  = 10'($urandom_range(0, 1023));
        bus.ballX     = 10'($urandom_range(0, 1023));
        bus.ballY     = 10'($urandom_range(0, 1023));
        @(negedge frame_clk);
        exp_f = (h < 4);
        exp_b = (h < 4);
        total++;
        if (bus.shotFinished !== exp_f || bus.busy !== exp_b || bus.madeShot !== res_v) begin
          bad++;
          $display("[TB] FAIL %s hold %0d: fin=%b busy=%b made=%b required fin=%b busy=%b made=%b",
                   name, h, bus.shotFinished, bus.busy, bus.madeShot, exp_f, exp_b, res_v);
        end
      end
      bus.shotStart = 1'b0;
      bus.ballY     = 10'(START_Y);
      @(negedge frame_clk);
      total++;
      if (bus.shotFinished !== 1'b0 || bus.busy !== 1'b0 || bus.madeShot !== res_v) begin
        bad++;
        $display("[TB] FAIL %s idle after result: fin=%b busy=%b made=%b required fin=0 busy=0 made=%b",
                 name, bus.shotFinished, bus.busy, bus.madeShot, res_v);
      end
    end else begin
      reset = 1'b0;
      #1;
      total++;
      if (bus.shotFinished !== 1'b0 || bus.busy !== 1'b0 || bus.madeShot !== 2'b00) begin
        bad++;
        $display("[TB] FAIL %s cleanup reset: fin=%b busy=%b made=%b required 0/0/00",
                 name, bus.shotFinished, bus.busy, bus.madeShot);
      end
      @(negedge frame_clk);
      reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.shotStart = 1'b0;
    bus.releaseX  = 10'd0;
    bus.ballX     = 10'd0;
    bus.ballY     = 10'(START_Y);
    reset = 1'b0;
    repeat (2) @(negedge frame_clk);
    total++;
    if (bus.madeShot !== 2'b00 || bus.shotFinished !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset: made=%b fin=%b busy=%b required 00/0/0",
               bus.madeShot, bus.shotFinished, bus.busy);
    end
    reset = 1'b1;
    @(negedge frame_clk);
  endtask

  task automatic test_three();
    clear_traj();
    push(580, 300); push(580, 250); push(580, 200); push(580, 150);
    push(580, 120); push(580, 140); push(580, 165);
    run_shot(10'd100, "three");
  endtask

  task automatic test_back_to_back();
    clear_traj();
    push(580, 300); push(580, 250); push(580, 200); push(580, 150);
    push(580, 120); push(580, 140); push(580, 165);
    run_shot(10'd400, "two_first");
    run_shot(10'd400, "two_second");
  endtask

  task automatic test_miss();
    clear_traj();
    push(500, 300); push(500, 200); push(500, 120); push(500, 150);
    push(500, 170); push(500, 250); push(500, 350); push(500, 440);
    run_shot(10'd400, "floor_miss");
    clear_traj();
    push(580, 250); push(580, 150); push(500, 200); push(580, 120); push(580, 170);
    run_shot(10'd400, "rearm_score");
  endtask

  task automatic test_boundaries();
    cross_traj(560, 160);
    run_shot(10'd319, "xmin_three");
    cross_traj(600, 165);
    run_shot(10'd320, "xmax_two");
    cross_traj(559, 165);
    run_shot(10'd100, "left_of_hoop");
    cross_traj(601, 165);
    run_shot(10'd100, "right_of_hoop");
    clear_traj();
    push(500, 300); push(500, 400); push(500, 439); push(500, 440);
    run_shot(10'd100, "floor_edge");
  endtask

  task automatic test_priority();
    cross_traj(580, 450);
    run_shot(10'd400, "make_beats_floor");
    cross_traj(500, 450);
    run_shot(10'd400, "outside_floor");
  endtask

  task automatic test_upward_no_score();
    clear_traj();
    push(580, 200); push(580, 160); push(580, 150); push(580, 100);
    for (int i = 0; i < 20; i++) push(580, $urandom_range(60, 159));
    run_shot(10'd100, "upward_only");
  endtask

  task automatic test_reset_armed();
    @(negedge frame_clk);
    bus.shotStart = 1'b1;
    bus.releaseX  = 10'd100;
    bus.ballY     = 10'(START_Y);
    @(negedge frame_clk);
    bus.shotStart = 1'b0;
    bus.ballX     = 10'd580;
    bus.ballY     = 10'd150;
    @(negedge frame_clk);
    bus.ballY     = 10'd120;
    @(negedge frame_clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.madeShot !== 2'b00 || bus.shotFinished !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_armed async: made=%b fin=%b busy=%b required 00/0/0",
               bus.madeShot, bus.shotFinished, bus.busy);
    end
    bus.ballY = 10'd165;
    @(negedge frame_clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge frame_clk);
      total++;
      if (bus.madeShot !== 2'b00 || bus.shotFinished !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_armed after %0d: made=%b fin=%b busy=%b required 00/0/0",
                 i, bus.madeShot, bus.shotFinished, bus.busy);
      end
    end
    reset = 1'b0;
    @(negedge frame_clk);
    reset = 1'b1;
    bus.shotStart = 1'b1;
    bus.releaseX  = 10'd100;
    bus.ballY     = 10'(START_Y);
    @(negedge frame_clk);
    bus.shotStart = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL first_edge_start: busy=%b required 1", bus.busy);
    end
    reset = 1'b0;
    @(negedge frame_clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int y;
    int apex;
    int up;
    int down;
    int base;
    for (int s = 0; s < 25; s++) begin
      clear_traj();
      y    = START_Y;
      apex = $urandom_range(60, 200);
      up   = $urandom_range(15, 40);
      down = $urandom_range(10, 40);
      base = $urandom_range(520, 640);
      while (y > apex) begin
        y -= up;
        push(base + $urandom_range(0, 16) - 8, y);
      end
      while (y < 460) begin
        y += down;
        push(base + $urandom_range(0, 16) - 8, y);
      end
      run_shot(10'($urandom_range(0, 1023)), $sformatf("random%0d", s));
    end
  endtask

  initial begin
    test_reset();
    test_three();
    test_back_to_back();
    test_miss();
    test_boundaries();
    test_priority();
    test_upward_no_score();
    test_reset_armed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
